// File: rtl/prm_chk_pkg.sv
// Shared types for the PRM obstacle-check bank and its edge walker.
// A code packs three 5-bit joint fields, j0 in the low bits.
`timescale 1ns/1ps
package prm_chk_pkg;

    localparam int JOINTS = 3;
    localparam int JW     = 5;
    localparam int CODE_W = 15;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [JW-1:0]     jnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } walk_state_t;

    function automatic jnt_t field(input code_t c, input int idx);
        return c[idx*JW +: JW];
    endfunction

endpackage

// File: rtl/prm_walk_step.sv
// Next staircase sample: every joint not yet at its target moves one
// step toward it. Pure combinational.
`timescale 1ns/1ps
module prm_walk_step
    import prm_chk_pkg::*;
(
    input  code_t cur,
    input  code_t to,
    output code_t nxt,
    output logic  at_tgt
);

    jnt_t c;
    jnt_t t;

    always_comb begin
        nxt    = cur;
        c      = '0;
        t      = '0;
        for (int j = 0; j < JOINTS; j++) begin
            c = field(cur, j);
            t = field(to, j);
            if (c < t) begin
                nxt[j*JW +: JW] = c + 1'b1;
            end else if (c > t) begin
                nxt[j*JW +: JW] = c - 1'b1;
            end
        end
        at_tgt = (cur == to);
    end

endmodule

// File: rtl/prm_edge_walk_seq.sv
// Edge walker: issues staircase samples to the check bank and folds the
// delayed masks into one verdict. PRM_WALK_EARLY_ABORT_EN stops on first hit.
`timescale 1ns/1ps
module prm_edge_walk_seq
    import prm_chk_pkg::*;
#(
    parameter int NCHK = 16,
    parameter int HW   = $clog2(NCHK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CODE_W-1:0] req_from,
    input  logic [CODE_W-1:0] req_to,
    output logic [CODE_W-1:0] chk_code,
    output logic              chk_vld,
    input  logic [NCHK-1:0]   chk_mask,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_blocked,
    output logic [HW-1:0]     res_hit_idx,
    output logic [4:0]        res_hit_step,
    output logic [5:0]        res_steps
);

    walk_state_t state;
    walk_state_t nstate;

    code_t      cur_q;
    code_t      to_q;
    code_t      nxt;
    logic       at_tgt;
    logic [4:0] step_q;
    logic       eval_vld_q;
    logic [4:0] eval_step_q;
    logic [HW-1:0] hit_low;
    logic       accept;
    logic       first_hit;
    logic       abort;

    prm_walk_step u_step (
        .cur    (cur_q),
        .to     (to_q),
        .nxt    (nxt),
        .at_tgt (at_tgt)
    );

    assign accept    = req_valid & req_ready;
    assign first_hit = eval_vld_q & (|chk_mask) & ~res_blocked;

`ifdef PRM_WALK_EARLY_ABORT_EN
    assign abort = first_hit;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        hit_low = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (chk_mask[i]) begin
                hit_low = HW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            ST_IDLE:  if (req_valid) nstate = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    nstate = ST_DONE;
                end else if (at_tgt) begin
                    nstate = ST_DRAIN;
                end
            end
            ST_DRAIN: nstate = ST_DONE;
            ST_DONE:  if (res_ready) nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        chk_vld   = (state == ST_RUN);
        res_valid = (state == ST_DONE);
        chk_code  = chk_vld ? cur_q : '0;
    end

    // Masks arrive one cycle behind their sample, so tag evaluation with
    // a delayed valid and step index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q        <= '0;
            to_q         <= '0;
            step_q       <= '0;
            eval_vld_q   <= 1'b0;
            eval_step_q  <= '0;
            res_blocked  <= 1'b0;
            res_hit_idx  <= '0;
            res_hit_step <= '0;
            res_steps    <= '0;
        end else begin
            eval_vld_q  <= (state == ST_RUN) & ~abort;
            eval_step_q <= step_q;
            if (accept) begin
                cur_q        <= req_from;
                to_q         <= req_to;
                step_q       <= '0;
                res_blocked  <= 1'b0;
                res_hit_idx  <= '0;
                res_hit_step <= '0;
                res_steps    <= '0;
            end else begin
                if (state == ST_RUN && !at_tgt && !abort) begin
                    cur_q  <= nxt;
                    step_q <= step_q + 1'b1;
                end
                if (eval_vld_q) begin
                    res_steps <= res_steps + 1'b1;
                end
                if (first_hit) begin
                    res_blocked  <= 1'b1;
                    res_hit_idx  <= hit_low;
                    res_hit_step <= eval_step_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_prm_edge_walk_seq.sv
// Directed bench for prm_edge_walk_seq with a one-cycle-latency bank model
// that raises a programmed mask for one chosen sample code.
`timescale 1ns/1ps
module tb_prm_edge_walk_seq;

    localparam int NCHK = 16;
    localparam int HW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [14:0]   req_from;
    logic [14:0]   req_to;
    logic [14:0]   chk_code;
    logic          chk_vld;
    logic [NCHK-1:0] chk_mask;
    logic          res_valid;
    logic          res_ready;
    logic          res_blocked;
    logic [HW-1:0] res_hit_idx;
    logic [4:0]    res_hit_step;
    logic [5:0]    res_steps;

    logic [14:0]   hit_code;
    logic [NCHK-1:0] hit_mask;
    logic [14:0]   bank_code_d;
    logic          bank_vld_d;

    logic [14:0]   samp_q[$];
    int            res_cyc;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    prm_edge_walk_seq #(.NCHK(NCHK), .HW(HW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_from     (req_from),
        .req_to       (req_to),
        .chk_code     (chk_code),
        .chk_vld      (chk_vld),
        .chk_mask     (chk_mask),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_blocked  (res_blocked),
        .res_hit_idx  (res_hit_idx),
        .res_hit_step (res_hit_step),
        .res_steps    (res_steps)
    );

    // Bank answers one cycle after the sample is presented.
    always @(posedge clk) begin
        bank_code_d <= chk_code;
        bank_vld_d  <= chk_vld;
    end

    assign chk_mask = (bank_vld_d && bank_code_d == hit_code) ? hit_mask : '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [14:0] f, input logic [14:0] t);
        @(negedge clk);
        chk("launch_req_ready", {31'd0, req_ready}, 32'd1);
        req_from  = f;
        req_to    = t;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic collect();
        samp_q.delete();
        res_cyc = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (chk_vld) samp_q.push_back(chk_code);
            if (res_valid) begin
                res_cyc = n;
                break;
            end
        end
        if (res_cyc == 0) chk("res_valid_timeout", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic release_res();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    logic [14:0] exp4 [4];
    int          seen;

    initial begin
        exp4[0] = 15'h0000;
        exp4[1] = 15'h0420;
        exp4[2] = 15'h0820;
        exp4[3] = 15'h0C20;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_from  = '0;
        req_to    = '0;
        res_ready = 1'b0;
        hit_code  = '0;
        hit_mask  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_chk_vld", {31'd0, chk_vld}, 32'd0);
        chk("rst_chk_code", {17'd0, chk_code}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_blocked", {31'd0, res_blocked}, 32'd0);
        chk("rst_hit_idx", {28'd0, res_hit_idx}, 32'd0);
        chk("rst_hit_step", {27'd0, res_hit_step}, 32'd0);
        chk("rst_steps", {26'd0, res_steps}, 32'd0);
        rst_n = 1'b1;

        // Clear 4-sample staircase
        launch(15'h0000, 15'h0C20);
        collect();
        chk("e1_nsamp", samp_q.size(), 32'd4);
        for (int k = 0; k < 4 && k < samp_q.size(); k++)
            chk("e1_sample", {17'd0, samp_q[k]}, {17'd0, exp4[k]});
        chk("e1_res_cyc", res_cyc, 32'd6);
        chk("e1_steps", {26'd0, res_steps}, 32'd4);
        chk("e1_blocked", {31'd0, res_blocked}, 32'd0);

        // Hold result for 5 cycles with a pending request
        req_from  = 15'h1234;
        req_to    = 15'h1234;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_steps", {26'd0, res_steps}, 32'd4);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("post_release_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        // Zero-length edge 0x1234 -> 0x1234
        collect();
        chk("e0_nsamp", samp_q.size(), 32'd1);
        if (samp_q.size() > 0)
            chk("e0_sample", {17'd0, samp_q[0]}, 32'h1234);
        chk("e0_res_cyc", res_cyc, 32'd3);
        chk("e0_steps", {26'd0, res_steps}, 32'd1);
        chk("e0_blocked", {31'd0, res_blocked}, 32'd0);
        release_res();

        // Hit on sample 2 with mask 0x0030
        hit_code = 15'h0820;
        hit_mask = 16'h0030;
        launch(15'h0000, 15'h0C20);
        collect();
        chk("hit_blocked", {31'd0, res_blocked}, 32'd1);
        chk("hit_idx", {28'd0, res_hit_idx}, 32'd4);
        chk("hit_step", {27'd0, res_hit_step}, 32'd2);
`ifdef PRM_WALK_EARLY_ABORT_EN
        chk("hit_steps", {26'd0, res_steps}, 32'd3);
        chk("hit_res_cyc", res_cyc, 32'd5);
`else
        chk("hit_steps", {26'd0, res_steps}, 32'd4);
        chk("hit_res_cyc", res_cyc, 32'd6);
`endif
        release_res();
        hit_mask = '0;

        // j0 31->0, j1 0->31
        launch(15'h001F, 15'h03E0);
        collect();
        chk("w_nsamp", samp_q.size(), 32'd32);
        for (int k = 0; k < 32 && k < samp_q.size(); k++)
            chk("w_sample", {17'd0, samp_q[k]},
                {17'd0, 5'd0, 5'(k), 5'(31 - k)});
        chk("w_steps", {26'd0, res_steps}, 32'd32);
        chk("w_res_cyc", res_cyc, 32'd34);
        chk("w_blocked", {31'd0, res_blocked}, 32'd0);
        release_res();

        // Reset in the middle of a 20-sample walk
        launch(15'h0000, 15'h0013);
        repeat (5) @(negedge clk);
        chk("mid_chk_vld", {31'd0, chk_vld}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_chk_vld", {31'd0, chk_vld}, 32'd0);
        chk("rst_mid_chk_code", {17'd0, chk_code}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid || chk_vld) seen = 1;
        end
        chk("rst_mid_no_result", seen, 32'd0);
        chk("rst_mid_idle_ready", {31'd0, req_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
